// File: rtl/ifdef_cond_eval_pkg.sv
// Shared types for the conditional-directive evaluator.
package ifdef_pkg;

  // Token opcodes delivered by the directive tokeniser.
  typedef enum logic [2:0] {
    OP_TEXT   = 3'd0,
    OP_DEF    = 3'd1,
    OP_UNDEF  = 3'd2,
    OP_IFDEF  = 3'd3,
    OP_IFNDEF = 3'd4,
    OP_ELSIF  = 3'd5,
    OP_ELSE   = 3'd6,
    OP_ENDIF  = 3'd7
  } op_e;

  // Per-nesting-level branch state.
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,  // branch taken, emitting
    SEARCH = 2'd1,  // nothing taken yet, parent active
    DONE   = 2'd2   // already taken, or parent inactive
  } lvl_e;

  // Top-level control state.
  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } fsm_e;

  // Bit positions inside the sticky err vector.
  localparam int ERR_OVERFLOW         = 3;
  localparam int ERR_UNDERFLOW        = 2;
  localparam int ERR_ELSE_DUP         = 1;
  localparam int ERR_ELSIF_AFTER_ELSE = 0;

  // State of a level after an ELSIF whose symbol is defined (cond=1) or not.
  function automatic lvl_e elsif_next(input lvl_e cur, input logic cond);
    lvl_e nxt;
    nxt = DONE;
    if (cur == SEARCH) nxt = cond ? ACTIVE : SEARCH;
    return nxt;
  endfunction

endpackage

// File: rtl/ifdef_cond_eval_if.sv
// Token stream in, TEXT stream out: the two valid/ready channels of the evaluator.
interface ifdef_cond_eval_if #(
  parameter int SYMW = 4,
  parameter int DW   = 8
);
  import ifdef_pkg::*;

  logic            in_valid;
  logic            in_ready;
  op_e             in_op;
  logic [SYMW-1:0] in_sym;
  logic [DW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;

  // Token producer / TEXT consumer side.
  modport master (
    output in_valid, in_op, in_sym, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Evaluator side.
  modport slave (
    input  in_valid, in_op, in_sym, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ifdef_level_stack.sv
// Nesting stack: one {lvl_e, seen_else} entry per open conditional.
module ifdef_level_stack
  import ifdef_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic           upd,
  input  lvl_e           push_lvl,
  input  logic           push_seen,
  input  lvl_e           upd_lvl,
  input  logic           upd_seen,
  output logic [DPW-1:0] depth,
  output lvl_e           top_lvl,
  output logic           top_seen,
  output logic           full,
  output logic           empty
);

  logic [DPW-1:0] depth_q, depth_d;
  lvl_e           lvl_q  [DEPTH];
  lvl_e           lvl_d  [DEPTH];
  logic           seen_q [DEPTH];
  logic           seen_d [DEPTH];

  // Depth moves by one on push or pop; the caller never requests both.
  always_comb begin
    depth_d = depth_q;
    if (push)     depth_d = depth_q + 1'b1;
    else if (pop) depth_d = depth_q - 1'b1;
  end

  // Depth register.
  always_ff @(posedge clk) begin
    if (rst) depth_q <= '0;
    else     depth_q <= depth_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_lvl
      localparam logic [DPW-1:0] SLOT = DPW'(gi);
      localparam logic [DPW-1:0] TOP  = DPW'(gi + 1);

      // Entry gi is written by a push landing on it, or an update while it is on top.
      always_comb begin
        lvl_d[gi]  = lvl_q[gi];
        seen_d[gi] = seen_q[gi];
        if (push && depth_q == SLOT) begin
          lvl_d[gi]  = push_lvl;
          seen_d[gi] = push_seen;
        end else if (upd && depth_q == TOP) begin
          lvl_d[gi]  = upd_lvl;
          seen_d[gi] = upd_seen;
        end
      end

      // Entry storage.
      always_ff @(posedge clk) begin
        if (rst) begin
          lvl_q[gi]  <= DONE;
          seen_q[gi] <= 1'b0;
        end else begin
          lvl_q[gi]  <= lvl_d[gi];
          seen_q[gi] <= seen_d[gi];
        end
      end
    end
  endgenerate

  // Top-of-stack read; an empty stack reads as DONE with no else seen.
  always_comb begin
    top_lvl  = DONE;
    top_seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DPW'(i + 1)) begin
        top_lvl  = lvl_q[i];
        top_seen = seen_q[i];
      end
    end
  end

  assign depth = depth_q;
  assign full  = (depth_q == DPW'(DEPTH));
  assign empty = (depth_q == '0);

endmodule

// File: rtl/ifdef_cond_eval.sv
// Conditional-directive evaluator: macro table, nesting control, error lock and TEXT output register.
module ifdef_cond_eval
  import ifdef_pkg::*;
#(
  parameter int NSYM  = 16,
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int DPW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  ifdef_cond_eval_if.slave bus,
  output logic [DPW-1:0]   depth,
  output logic             balanced,
  output logic [3:0]       err,
  output logic             locked
);

  logic [NSYM-1:0] def_q, def_d;
  logic [3:0]      err_q, err_d;
  fsm_e            fsm_q, fsm_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_data_q, out_data_d;

  logic push, pop, upd, push_seen, upd_seen;
  lvl_e push_lvl, upd_lvl, top_lvl;
  logic top_seen, full, empty;
  logic accept, cur_active, sym_def;

  ifdef_level_stack #(.DEPTH(DEPTH), .DPW(DPW)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .upd       (upd),
    .push_lvl  (push_lvl),
    .push_seen (push_seen),
    .upd_lvl   (upd_lvl),
    .upd_seen  (upd_seen),
    .depth     (depth),
    .top_lvl   (top_lvl),
    .top_seen  (top_seen),
    .full      (full),
    .empty     (empty)
  );

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign cur_active   = empty || (top_lvl == ACTIVE);
  assign sym_def      = def_q[bus.in_sym];

  // Token decode: next table, stack command, errors, FSM and output slot.
  always_comb begin
    def_d       = def_q;
    err_d       = err_q;
    fsm_d       = fsm_q;
    push        = 1'b0;
    pop         = 1'b0;
    upd         = 1'b0;
    push_lvl    = DONE;
    push_seen   = 1'b0;
    upd_lvl     = top_lvl;
    upd_seen    = top_seen;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_data_d  = out_data_q;

    if (accept && fsm_q == RUN) begin
      unique case (bus.in_op)
        OP_TEXT: begin
          if (cur_active) begin
            out_valid_d = 1'b1;
            out_data_d  = bus.in_data;
          end
        end
        OP_DEF:   if (cur_active) def_d[bus.in_sym] = 1'b1;
        OP_UNDEF: if (cur_active) def_d[bus.in_sym] = 1'b0;
        OP_IFDEF, OP_IFNDEF: begin
          if (full) begin
            err_d[ERR_OVERFLOW] = 1'b1;
            fsm_d               = LOCK;
          end else begin
            push = 1'b1;
            if (!cur_active)                         push_lvl = DONE;
            else if (sym_def ^ (bus.in_op == OP_IFNDEF)) push_lvl = ACTIVE;
            else                                     push_lvl = SEARCH;
          end
        end
        OP_ELSIF: begin
          if (empty) begin
            err_d[ERR_UNDERFLOW] = 1'b1;
            fsm_d                = LOCK;
          end else if (top_seen) begin
            err_d[ERR_ELSIF_AFTER_ELSE] = 1'b1;
            fsm_d                       = LOCK;
          end else begin
            upd     = 1'b1;
            upd_lvl = elsif_next(top_lvl, sym_def);
          end
        end
        OP_ELSE: begin
          if (empty) begin
            err_d[ERR_UNDERFLOW] = 1'b1;
            fsm_d                = LOCK;
          end else if (top_seen) begin
            err_d[ERR_ELSE_DUP] = 1'b1;
            fsm_d               = LOCK;
          end else begin
            upd      = 1'b1;
            upd_lvl  = (top_lvl == SEARCH) ? ACTIVE : DONE;
            upd_seen = 1'b1;
          end
        end
        OP_ENDIF: begin
          if (empty) begin
            err_d[ERR_UNDERFLOW] = 1'b1;
            fsm_d                = LOCK;
          end else begin
            pop = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; reset clears the table, errors and any pending output.
  always_ff @(posedge clk) begin
    if (rst) begin
      def_q       <= '0;
      err_q       <= '0;
      fsm_q       <= RUN;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      def_q       <= def_d;
      err_q       <= err_d;
      fsm_q       <= fsm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign err           = err_q;
  assign locked        = (fsm_q == LOCK);
  assign balanced      = empty && (fsm_q == RUN);

endmodule

// File: tb/tb_ifdef_cond_eval.sv
// Directed bench for ifdef_cond_eval.
module tb_ifdef_cond_eval;
  import ifdef_pkg::*;

  localparam int NSYM  = 16;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int SYMW  = 4;
  localparam int DPW   = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DPW-1:0] depth;
  logic           balanced;
  logic [3:0]     err;
  logic           locked;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] got_q[$];
  int max_depth = 0;

  ifdef_cond_eval_if #(.SYMW(SYMW), .DW(DW)) bus ();

  ifdef_cond_eval #(.NSYM(NSYM), .DEPTH(DEPTH), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .depth    (depth),
    .balanced (balanced),
    .err      (err),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  // Record each transfer on the negedge before the edge that completes it.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    if (int'(depth) > max_depth) max_depth = int'(depth);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_q.delete();
    max_depth = 0;
  endtask

  task automatic send(input op_e op, input int sym, input int data);
    bit ok = 0;
    bus.in_op    = op;
    bus.in_sym   = SYMW'(sym);
    bus.in_data  = DW'(data);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    $display("token op=%s sym=%0d data=%02h accepted=%0d", op.name(), sym, data, ok);
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = OP_TEXT;
    bus.in_sym    = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    // Reset state.
    do_reset();
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data",  32'(bus.out_data), 0);
    chk("rst_depth",     32'(depth), 0);
    chk("rst_err",       32'(err), 0);
    chk("rst_locked",    32'(locked), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 1);
    chk("rst_balanced",  32'(balanced), 1);

    // 1: elsif chain picks the defined symbol.
    do_reset();
    send(OP_DEF, 4, 0);
    send(OP_IFDEF, 1, 0);
    send(OP_ELSIF, 2, 0);
    send(OP_ELSIF, 3, 0);
    send(OP_ELSIF, 4, 0);
    send(OP_TEXT, 0, 'hA4);
    send(OP_ELSE, 0, 0);
    send(OP_TEXT, 0, 'hEE);
    send(OP_ENDIF, 0, 0);
    idle(3);
    @(negedge clk);
    chk("t1_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("t1_data", 32'(got_q[0]), 'hA4);
    chk("t1_depth", 32'(depth), 0);
    chk("t1_balanced", 32'(balanced), 1);
    chk("t1_err", 32'(err), 0);

    // 2: progressive 4-level nest.
    do_reset();
    send(OP_DEF, 1, 0);
    send(OP_IFDEF, 1, 0);
    send(OP_TEXT, 0, 'h01);
    send(OP_DEF, 2, 0);
    send(OP_IFDEF, 2, 0);
    send(OP_TEXT, 0, 'h02);
    send(OP_DEF, 3, 0);
    send(OP_IFNDEF, 9, 0);
    send(OP_TEXT, 0, 'h03);
    send(OP_DEF, 4, 0);
    send(OP_IFDEF, 5, 0);
    send(OP_TEXT, 0, 'hFF);
    send(OP_ELSIF, 4, 0);
    send(OP_TEXT, 0, 'h04);
    send(OP_ELSE, 0, 0);
    send(OP_TEXT, 0, 'hFF);
    send(OP_ENDIF, 0, 0);
    send(OP_ELSE, 0, 0);
    send(OP_TEXT, 0, 'hFF);
    send(OP_ENDIF, 0, 0);
    send(OP_ELSE, 0, 0);
    send(OP_TEXT, 0, 'hFF);
    send(OP_ENDIF, 0, 0);
    send(OP_ELSE, 0, 0);
    send(OP_TEXT, 0, 'hFF);
    send(OP_ENDIF, 0, 0);
    idle(3);
    @(negedge clk);
    chk("t2_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      chk($sformatf("t2_data%0d", i), 32'(got_q[i]), 32'(i + 1));
    chk("t2_max_depth", 32'(max_depth), 4);
    chk("t2_err", 32'(err), 0);
    chk("t2_depth", 32'(depth), 0);

    // 3: DEF inside an inactive branch is a no-op.
    do_reset();
    send(OP_IFDEF, 5, 0);
    send(OP_DEF, 6, 0);
    send(OP_ENDIF, 0, 0);
    send(OP_IFDEF, 6, 0);
    send(OP_TEXT, 0, 'h66);
    send(OP_ENDIF, 0, 0);
    // UNDEF at top level removes a definition.
    send(OP_DEF, 7, 0);
    send(OP_UNDEF, 7, 0);
    send(OP_IFDEF, 7, 0);
    send(OP_TEXT, 0, 'h77);
    send(OP_ENDIF, 0, 0);
    idle(3);
    @(negedge clk);
    chk("t3_count", got_q.size(), 0);
    chk("t3_err", 32'(err), 0);

    // 4: overflow locks, further TEXT dropped, reset clears.
    do_reset();
    for (int i = 0; i < 9; i++) send(OP_IFDEF, 0, 0);
    send(OP_TEXT, 0, 'h11);
    idle(3);
    @(negedge clk);
    chk("t4_err", 32'(err), 4'b1000);
    chk("t4_locked", 32'(locked), 1);
    chk("t4_depth", 32'(depth), 8);
    chk("t4_balanced", 32'(balanced), 0);
    chk("t4_count", got_q.size(), 0);
    do_reset();
    @(negedge clk);
    chk("t4_rst_locked", 32'(locked), 0);
    chk("t4_rst_err", 32'(err), 0);
    chk("t4_rst_depth", 32'(depth), 0);

    // 5: underflow, else_dup, elsif_after_else.
    do_reset();
    send(OP_ENDIF, 0, 0);
    @(negedge clk);
    chk("t5_underflow", 32'(err), 4'b0100);
    chk("t5_locked", 32'(locked), 1);
    do_reset();
    send(OP_IFDEF, 0, 0);
    send(OP_ELSE, 0, 0);
    send(OP_ELSE, 0, 0);
    @(negedge clk);
    chk("t5_else_dup", 32'(err), 4'b0010);
    do_reset();
    send(OP_IFDEF, 0, 0);
    send(OP_ELSE, 0, 0);
    send(OP_TEXT, 0, 'h55);
    send(OP_ELSIF, 1, 0);
    send(OP_TEXT, 0, 'h56);
    idle(3);
    @(negedge clk);
    chk("t5_elsif_after_else", 32'(err), 4'b0001);
    chk("t5_count", got_q.size(), 1);
    if (got_q.size() > 0) chk("t5_data", 32'(got_q[0]), 'h55);

    // 6: back-pressure.
    do_reset();
    bus.out_ready = 1'b0;
    fork
      begin
        send(OP_TEXT, 0, 'h31);
        send(OP_TEXT, 0, 'h32);
        send(OP_TEXT, 0, 'h33);
      end
    join_none
    repeat (6) @(negedge clk);
    chk("t6_in_ready", 32'(bus.in_ready), 0);
    chk("t6_out_valid", 32'(bus.out_valid), 1);
    chk("t6_hold_data", 32'(bus.out_data), 'h31);
    chk("t6_count_held", got_q.size(), 0);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    idle(10);
    wait fork;
    @(negedge clk);
    chk("t6_count", got_q.size(), 3);
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      chk($sformatf("t6_data%0d", i), 32'(got_q[i]), 32'('h31 + i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
